wav_writer: RTL and testbench
=============================

WAV_WRITER -- requirements
Module: wav_writer

Interface
REQ-001 SHALL have no parameters; all WAV format fields are run-time inputs.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 rst  in  1  reset; asynchronous assert, active-high.
REQ-004 start  in  1  one-cycle pulse that begins a file when idle.
REQ-005 channel_len  in  2  channel count, latched on accepted start.
REQ-006 sample_rate  in  32  samples per second, latched on start.
REQ-007 sample_bits_per  in  16  bits per sample, latched on start.
REQ-008 data_size  in  32  payload byte count, latched on start.
REQ-009 in_valid / in_ready / in_data  in / out / in  1 / 1 / 16  sample-word stream.
REQ-010 out_valid / out_ready / out_data  out / in / out  1 / 1 / 16  file-word stream.
REQ-011 busy / done / error  out / out / out  1 / 1 / 1  status flags.

Function
REQ-012 Word packing: out word k SHALL carry file byte 2k in [15:8] and byte 2k+1 in [7:0]; multi-byte numeric fields SHALL be little-endian bytes.
REQ-013 States: IDLE, CALC, HDR, DATA, FIN, ERROR.
REQ-014 IDLE: start SHALL latch all config inputs and go to CALC; busy=0.
REQ-015 CALC: one cycle; SHALL register block_align=channel_len*sample_bits_per/8 (16b) and byte_rate=sample_rate*block_align (32b, truncated); go to HDR.
REQ-016 HDR SHALL emit 22 words in order: "RIFF", data_size+36, "WAVE", "fmt ", 16, 1 (PCM), channel_len, sample_rate, byte_rate, block_align, sample_bits_per, "data", data_size.
REQ-017 A word transfers when out_valid&&out_ready; out_data SHALL be held stable while out_valid&&!out_ready.
REQ-018 First header word SHALL be valid in the cycle after CALC (two cycles after start).
REQ-019 DATA SHALL forward exactly ceil(data_size/2) words from in to out through one output register; in_ready = in DATA && (!out_valid || out_ready).
REQ-020 in_ready SHALL be 0 in every state other than DATA; input words are never dropped or duplicated.
REQ-021 data_size=0: HDR SHALL go directly to FIN after word 21 transfers.
REQ-022 FIN: after the last word transfers, done SHALL pulse 1 cycle, then IDLE.
REQ-023 start while busy SHALL be ignored; busy=1 in CALC, HDR, DATA, FIN.
REQ-024 data_size+36 SHALL wrap modulo 2^32.
REQ-025 ERROR: error=1, out_valid=0, in_ready=0; left only by rst.

Reset
REQ-026 rst SHALL immediately force IDLE; out_valid, in_ready, busy, done, error=0; out_data=0; counters and latched config=0.
REQ-027 rst mid-file SHALL abort without completing the current word; next file restarts at word 0.

Configuration
REQ-028 Macro WAV_WRITER_CHECK_EN defined: on start, channel_len=0 or sample_bits_per not in {8,16,24,32} SHALL enter ERROR instead of CALC.
REQ-029 Macro undefined: no checking; ERROR unreachable; error tied 0.

Verification
REQ-030 44100 Hz, 2 ch, 16 bit, data_size=8, out_ready=1 -> words 0x5249,0x4646,0x2C00,0x0000,...,0x44AC,0x0000,0x10B1,0x0200,0x0400,0x1000,...,0x0800,0x0000, then 4 samples, done pulse.
REQ-031 Same file with out_ready toggled randomly -> identical word sequence, out_data stable during stalls.
REQ-032 data_size=5 -> 3 data words forwarded, in_ready low afterward, done once.
REQ-033 data_size=0 -> exactly 22 words, done, no in_ready assertion.
REQ-034 rst asserted mid-DATA, then new start -> stream restarts at 0x5249, busy/out_valid cleared immediately.
REQ-035 WAV_WRITER_CHECK_EN defined, channel_len=0 -> error=1, no output words; undefined -> normal 22-word header.

Source files
------------

// File: rtl/wav_writer.sv
// Streams a 44-byte PCM WAV header followed by the sample payload as 16-bit words.
// Optional config checking (channel count, bit depth) is enabled by defining WAV_WRITER_CHECK_EN.
module wav_writer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  channel_len,
  input  logic [31:0] sample_rate,
  input  logic [15:0] sample_bits_per,
  input  logic [31:0] data_size,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_HDR, S_DATA, S_FIN, S_ERROR
  } state_t;

  localparam logic [4:0] LAST_HDR = 5'd21;

  state_t      state_q, state_d;
  logic [1:0]  ch_q;
  logic [31:0] sr_q;
  logic [15:0] bits_q;
  logic [31:0] ds_q;
  logic [15:0] ba_q;
  logic [31:0] br_q;
  logic [31:0] rem_q;
  logic [4:0]  idx_q;
  logic [15:0] out_data_q;
  logic        out_valid_q;
  logic        done_q;

  logic [17:0] prod;
  logic [15:0] ba_calc;
  logic [31:0] br_calc;
  logic        cfg_bad;

  // Little-endian byte pair packed big-end first into the output word.
  function automatic logic [15:0] le16(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  function automatic logic [15:0] hdr_word(
    input logic [4:0]  idx,
    input logic [1:0]  ch,
    input logic [31:0] sr,
    input logic [15:0] bits,
    input logic [31:0] ds,
    input logic [15:0] ba,
    input logic [31:0] br
  );
    logic [31:0] riff;
    riff = ds + 32'd36;
    case (idx)
      5'd0:  return 16'h5249;
      5'd1:  return 16'h4646;
      5'd2:  return le16(riff[15:0]);
      5'd3:  return le16(riff[31:16]);
      5'd4:  return 16'h5741;
      5'd5:  return 16'h5645;
      5'd6:  return 16'h666D;
      5'd7:  return 16'h7420;
      5'd8:  return 16'h1000;
      5'd9:  return 16'h0000;
      5'd10: return 16'h0100;
      5'd11: return le16({14'd0, ch});
      5'd12: return le16(sr[15:0]);
      5'd13: return le16(sr[31:16]);
      5'd14: return le16(br[15:0]);
      5'd15: return le16(br[31:16]);
      5'd16: return le16(ba);
      5'd17: return le16(bits);
      5'd18: return 16'h6461;
      5'd19: return 16'h7461;
      5'd20: return le16(ds[15:0]);
      5'd21: return le16(ds[31:16]);
      default: return 16'h0000;
    endcase
  endfunction

  assign prod    = 18'(ch_q) * 18'(bits_q);
  assign ba_calc = 16'(prod >> 3);
  assign br_calc = sr_q * {16'd0, ba_calc};

`ifdef WAV_WRITER_CHECK_EN
  assign cfg_bad = (channel_len == 2'd0) ||
                   !((sample_bits_per == 16'd8)  || (sample_bits_per == 16'd16) ||
                     (sample_bits_per == 16'd24) || (sample_bits_per == 16'd32));
`else
  assign cfg_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = cfg_bad ? S_ERROR : S_CALC;
      S_CALC:  state_d = S_HDR;
      S_HDR:   if (out_ready && (idx_q == LAST_HDR))
                 state_d = (ds_q == 32'd0) ? S_FIN : S_DATA;
      S_DATA:  if (in_valid && in_ready && (rem_q == 32'd1)) state_d = S_FIN;
      S_FIN:   if (!out_valid_q || out_ready) state_d = S_IDLE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  // Config latch, derived fields and the single output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q        <= '0;
      sr_q        <= '0;
      bits_q      <= '0;
      ds_q        <= '0;
      ba_q        <= '0;
      br_q        <= '0;
      rem_q       <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            ch_q   <= channel_len;
            sr_q   <= sample_rate;
            bits_q <= sample_bits_per;
            ds_q   <= data_size;
          end
        end
        S_CALC: begin
          ba_q        <= ba_calc;
          br_q        <= br_calc;
          rem_q       <= (ds_q >> 1) + {31'd0, ds_q[0]};
          idx_q       <= 5'd0;
          out_data_q  <= 16'h5249;
          out_valid_q <= 1'b1;
        end
        S_HDR: begin
          if (out_ready) begin
            if (idx_q == LAST_HDR) begin
              out_valid_q <= 1'b0;
            end else begin
              idx_q      <= idx_q + 5'd1;
              out_data_q <= hdr_word(idx_q + 5'd1, ch_q, sr_q, bits_q, ds_q, ba_q, br_q);
            end
          end
        end
        S_DATA: begin
          if (in_valid && in_ready) begin
            out_data_q  <= in_data;
            out_valid_q <= 1'b1;
            rem_q       <= rem_q - 32'd1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        S_FIN: begin
          if (!out_valid_q || out_ready) begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        default: out_valid_q <= 1'b0;
      endcase
    end
  end

  assign in_ready  = (state_q == S_DATA) && (!out_valid_q || out_ready);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = done_q;
  assign busy      = (state_q == S_CALC) || (state_q == S_HDR) ||
                     (state_q == S_DATA) || (state_q == S_FIN);
`ifdef WAV_WRITER_CHECK_EN
  assign error = (state_q == S_ERROR);
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_wav_writer.sv
// Scoreboard bench for wav_writer: header words modelled from a byte image, samples queued on handshake.
module tb_wav_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  channel_len = '0;
  logic [31:0] sample_rate = '0;
  logic [15:0] sample_bits_per = '0;
  logic [31:0] data_size = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        busy, done, error;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  wav_writer dut (
    .clk(clk), .rst(rst), .start(start), .channel_len(channel_len),
    .sample_rate(sample_rate), .sample_bits_per(sample_bits_per), .data_size(data_size),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Builds the 44-byte header image and pushes its 22 words.
  task automatic push_hdr(input logic [1:0] ch, input logic [31:0] sr,
                          input logic [15:0] bits, input logic [31:0] ds);
    logic [7:0]  b [44];
    logic [31:0] ba, br, riff;
    string tags = "RIFFWAVEfmt data";
    ba   = ((32'(ch) * 32'(bits)) / 32'd8) & 32'hFFFF;
    br   = sr * ba;
    riff = ds + 32'd36;
    for (int i = 0; i < 4; i++) begin
      b[i]      = tags[i];
      b[8 + i]  = tags[4 + i];
      b[12 + i] = tags[8 + i];
      b[36 + i] = tags[12 + i];
      b[4 + i]  = 8'(riff >> (8 * i));
      b[16 + i] = 8'(32'd16 >> (8 * i));
      b[24 + i] = 8'(sr >> (8 * i));
      b[28 + i] = 8'(br >> (8 * i));
      b[40 + i] = 8'(ds >> (8 * i));
    end
    b[20] = 8'd1;  b[21] = 8'd0;
    b[22] = 8'(ch); b[23] = 8'd0;
    b[32] = ba[7:0]; b[33] = ba[15:8];
    b[34] = bits[7:0]; b[35] = bits[15:8];
    for (int k = 0; k < 22; k++) exp_q.push_back({b[2 * k], b[2 * k + 1]});
  endtask

  task automatic run_file(input string nm, input logic [1:0] ch, input logic [31:0] sr,
                          input logic [15:0] bits, input logic [31:0] ds,
                          input bit rand_rdy, input int abort_at);
    int words_out = 0, acc = 0, done_cnt = 0, post = 0, viol = 0, stall_bad = 0;
    int need;
    bit prev_stall = 0;
    logic [15:0] prev_data = '0;
    need = int'((ds >> 1) + {31'd0, ds[0]});
    exp_q.delete();
    @(negedge clk);
    start = 1'b1; channel_len = ch; sample_rate = sr; sample_bits_per = bits; data_size = ds;
    push_hdr(ch, sr, bits, ds);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start           = (c == 5);
      channel_len     = 2'($urandom);
      sample_rate     = $urandom;
      sample_bits_per = 16'($urandom);
      data_size       = $urandom;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      #1;
      if (c == 0) begin
        chk({nm, "_busy_calc"}, {31'd0, busy}, 32'd1);
        chk({nm, "_vld_calc"}, {31'd0, out_valid}, 32'd0);
      end
      if (c == 1) chk({nm, "_first_vld"}, {31'd0, out_valid}, 32'd1);
      if (prev_stall && (!out_valid || out_data !== prev_data)) stall_bad++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (in_ready && (words_out < 22 || acc >= need)) viol++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk({nm, "_extra_word"}, {16'd0, out_data}, 32'hDEAD_0000);
        else chk($sformatf("%s_w%0d", nm, words_out), {16'd0, out_data}, {16'd0, exp_q.pop_front()});
        words_out++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        acc++;
      end
      if (done) done_cnt++;
      if (abort_at > 0 && words_out >= abort_at) begin
        rst = 1'b1;
        #1;
        chk({nm, "_abort_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_abort_vld"}, {31'd0, out_valid}, 32'd0);
        chk({nm, "_abort_inrdy"}, {31'd0, in_ready}, 32'd0);
        chk({nm, "_abort_data"}, {16'd0, out_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        return;
      end
      if (done_cnt > 0) post++;
      if (post > 4) break;
      if (c == 2999) chk({nm, "_timeout"}, 32'd1, 32'd0);
    end
    in_valid = 1'b0;
    chk({nm, "_done_once"}, 32'(done_cnt), 32'd1);
    chk({nm, "_words"}, 32'(words_out), 32'(22 + need));
    chk({nm, "_accepted"}, 32'(acc), 32'(need));
    chk({nm, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    chk({nm, "_inrdy_bad"}, 32'(viol), 32'd0);
    chk({nm, "_stall_bad"}, 32'(stall_bad), 32'd0);
    chk({nm, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_inrdy", {31'd0, in_ready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, error}, 32'd0);
    chk("rst_data", {16'd0, out_data}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_file("cd_ready", 2'd2, 32'd44100, 16'd16, 32'd8, 1'b0, 0);
    run_file("cd_stall", 2'd2, 32'd44100, 16'd16, 32'd8, 1'b1, 0);
    run_file("odd5", 2'd1, 32'd48000, 16'd24, 32'd5, 1'b1, 0);
    run_file("empty", 2'd3, 32'd8000, 16'd8, 32'd0, 1'b1, 0);
    run_file("wrap", 2'd2, 32'd96000, 16'd32, 32'hFFFF_FFF0, 1'b1, 22);
    run_file("abort", 2'd2, 32'd22050, 16'd16, 32'd40, 1'b1, 25);
    run_file("restart", 2'd1, 32'd16000, 16'd8, 32'd3, 1'b0, 0);

`ifdef WAV_WRITER_CHECK_EN
    begin
      int vcnt = 0;
      @(negedge clk);
      start = 1'b1; channel_len = 2'd0; sample_bits_per = 16'd16; data_size = 32'd4;
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        start = 1'b0;
        #1;
        if (out_valid || in_ready) vcnt++;
      end
      chk("err_flag", {31'd0, error}, 32'd1);
      chk("err_noout", 32'(vcnt), 32'd0);
      rst = 1'b1;
      #1;
      chk("err_cleared", {31'd0, error}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
    end
`else
    run_file("ch0", 2'd0, 32'd44100, 16'd16, 32'd0, 1'b0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
